// File: rtl/regfile_write_sequencer_pkg.sv
// Shared definitions for the register-file write sequencer.
//   N_DEF / M_DEF : default address / data widths
//   state_e       : sequencer states (CLEAR sweep, RUN drain)
//   PC_IDX        : index of the program counter (R15) for the default width
//   pc_idx()      : same index for an arbitrary address width
package regfile_pkg;

  localparam int N_DEF  = 4;
  localparam int M_DEF  = 32;
  localparam int PC_IDX = (1 << N_DEF) - 1;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  function automatic int pc_idx(input int n);
    return (1 << n) - 1;
  endfunction

endpackage

// File: rtl/regfile_write_sequencer_wb_fifo.sv
// wb_fifo: write-request buffer for the register-file write sequencer.
// Ports:
//   clk, reset          clock, synchronous active-low reset (empties buffer)
//   push, push_data     enqueue one entry (ignored when full)
//   pop                 dequeue the head entry (ignored when empty)
//   pop_data            current head entry (valid while count != 0)
//   count               number of stored entries, 0..DEPTH
module wb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  // Guards keep the count inside 0..DEPTH even if a caller misbehaves.
  assign do_push  = push && (count < CW'(DEPTH));
  assign do_pop   = pop && (count != '0);
  assign pop_data = mem[rd_ptr];

  // Power-of-two depth: pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_write_sequencer.sv
// regfile_write_sequencer: buffers register-file write requests and issues
// them one per cycle on a registered WE3/A3/WD3 write port. Writes to the PC
// (highest register index) are discarded and flagged on drop_r15.
// With macro REGFILE_INIT_CLEAR_EN defined, reset is followed by a sweep that
// writes zero to R0..R(2^N-2) before requests are accepted; without it the
// sequencer enters RUN straight out of reset.
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   req_valid/req_ready         request handshake
//   req_addr, req_data          destination register and value
//   WE3, A3, WD3                register-file write port (registered)
//   busy                        sweep active or buffer non-empty
//   drop_r15                    one-cycle pulse when a PC write is discarded
//   pending                     buffered request count
module regfile_write_sequencer
  import regfile_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int M     = M_DEF,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [N-1:0]           req_addr,
  input  logic [M-1:0]           req_data,
  output logic                   WE3,
  output logic [N-1:0]           A3,
  output logic [M-1:0]           WD3,
  output logic                   busy,
  output logic                   drop_r15,
  output logic [$clog2(DEPTH):0] pending
);

  localparam int          CW   = $clog2(DEPTH) + 1;
  localparam logic [N-1:0] PC_A = N'(pc_idx(N));

  state_e         state_q, state_d;
  logic           push, pop;
  logic [N+M-1:0] head;
  logic [N-1:0]   head_addr;
  logic [M-1:0]   head_data;
  logic           we_d, drop_d;
  logic [N-1:0]   a3_d;
  logic [M-1:0]   wd_d;

`ifdef REGFILE_INIT_CLEAR_EN
  logic [N-1:0]   sweep_q, sweep_d;
`endif

  assign head_addr = head[N+M-1:M];
  assign head_data = head[M-1:0];

  // Ready is a function of registered state only, so a same-edge pop never
  // opens a slot early.
  assign req_ready = (state_q == RUN) && (pending < CW'(DEPTH));
  assign push      = req_valid && req_ready;
  assign busy      = (state_q != RUN) || (pending != '0);

  wb_fifo #(
    .W     (N + M),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({req_addr, req_data}),
    .pop       (pop),
    .pop_data  (head),
    .count     (pending)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    we_d    = 1'b0;
    drop_d  = 1'b0;
    a3_d    = A3;
    wd_d    = WD3;
`ifdef REGFILE_INIT_CLEAR_EN
    sweep_d = sweep_q;
`endif
    case (state_q)
      CLEAR: begin
`ifdef REGFILE_INIT_CLEAR_EN
        we_d    = 1'b1;
        a3_d    = sweep_q;
        wd_d    = '0;
        sweep_d = sweep_q + 1'b1;
        // Last sweep target is the register just below the PC.
        if (sweep_q == PC_A - 1'b1) state_d = RUN;
`else
        state_d = RUN;
`endif
      end
      RUN: begin
        if (pending != '0) begin
          pop = 1'b1;
          if (head_addr == PC_A) begin
            drop_d = 1'b1;
          end else begin
            we_d = 1'b1;
            a3_d = head_addr;
            wd_d = head_data;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
`ifdef REGFILE_INIT_CLEAR_EN
      state_q  <= CLEAR;
      sweep_q  <= '0;
`else
      state_q  <= RUN;
`endif
      WE3      <= 1'b0;
      A3       <= '0;
      WD3      <= '0;
      drop_r15 <= 1'b0;
    end else begin
      state_q  <= state_d;
`ifdef REGFILE_INIT_CLEAR_EN
      sweep_q  <= sweep_d;
`endif
      WE3      <= we_d;
      A3       <= a3_d;
      WD3      <= wd_d;
      drop_r15 <= drop_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_sequencer.sv
module tb_regfile_write_sequencer;

  localparam int N     = 4;
  localparam int M     = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int PC    = (1 << N) - 1;

`ifdef REGFILE_INIT_CLEAR_EN
  localparam bit SWEEP = 1'b1;
`else
  localparam bit SWEEP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic [N-1:0]  req_addr = '0;
  logic [M-1:0]  req_data = '0;
  logic          req_ready, WE3, busy, drop_r15;
  logic [N-1:0]  A3;
  logic [M-1:0]  WD3;
  logic [CW-1:0] pending;

  always #5 clk = ~clk;

  regfile_write_sequencer #(.N(N), .M(M), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .WE3       (WE3),
    .A3        (A3),
    .WD3       (WD3),
    .busy      (busy),
    .drop_r15  (drop_r15),
    .pending   (pending)
  );

  typedef struct packed {
    logic [N-1:0] a;
    logic [M-1:0] d;
  } req_t;

  // Reference model: a queue of accepted requests, a sweep counter and the
  // expected contents of the write port.
  req_t         q[$];
  bit           run = 1'b0;
  bit           known = 1'b0;
  int           sweep = 0;
  logic         e_we = 1'b0, e_drop = 1'b0;
  logic [N-1:0] e_a3 = '0;
  logic [M-1:0] e_wd = '0;
  int           r15_writes = 0;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check handshake/status before the edge,
  // advance the model at the edge, check the write port after it.
  task automatic step(input bit rst_n, input bit v, input logic [N-1:0] a,
                      input logic [M-1:0] d);
    bit   exp_rdy, acc;
    req_t h;
    reset     = rst_n;
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    @(negedge clk);
    exp_rdy = run && (q.size() < DEPTH);
    if (known) begin
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("pending",   64'(pending),   64'(q.size()));
      chk("busy",      64'(busy),      64'(!run || q.size() > 0));
    end
    acc = v && exp_rdy;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      run    = !SWEEP;
      sweep  = 0;
      e_we   = 1'b0;
      e_drop = 1'b0;
      e_a3   = '0;
      e_wd   = '0;
      known  = 1'b1;
    end else if (known) begin
      e_we   = 1'b0;
      e_drop = 1'b0;
      if (!run) begin
        e_we = 1'b1;
        e_a3 = N'(sweep);
        e_wd = '0;
        sweep++;
        if (sweep == PC) run = 1'b1;
      end else if (q.size() > 0) begin
        h = q.pop_front();
        if (h.a == N'(PC)) e_drop = 1'b1;
        else begin
          e_we = 1'b1;
          e_a3 = h.a;
          e_wd = h.d;
        end
      end
      if (acc) q.push_back('{a: a, d: d});
    end
    #1;
    if (known) begin
      chk("WE3",      64'(WE3),      64'(e_we));
      chk("drop_r15", 64'(drop_r15), 64'(e_drop));
      if (run || e_we) begin
        chk("A3",  64'(A3),  64'(e_a3));
        chk("WD3", 64'(WD3), 64'(e_wd));
      end
      if (WE3 === 1'b1 && A3 === N'(PC)) r15_writes++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0);
  endtask

  initial begin
    // Reset, then sweep (or immediate RUN without the sweep).
    step(1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0);
    chk("rst_WE3", 64'(WE3), 64'(0));
    chk("rst_pending", 64'(pending), 64'(0));
    idle(SWEEP ? 15 : 2);

    // Single request: written two edges after acceptance.
    step(1'b1, 1'b1, 4'd3, 32'h0F0F0F0F);
    step(1'b1, 1'b0, '0, '0);
    chk("single_we", 64'(WE3), 64'(1));
    chk("single_a3", 64'(A3), 64'(3));
    chk("single_wd", 64'(WD3), 64'(32'h0F0F0F0F));
    idle(2);

    // PC write is dropped, the following write goes through.
    step(1'b1, 1'b1, 4'd15, 32'hDEADBEEF);
    step(1'b1, 1'b1, 4'd2, 32'h12345678);
    chk("r15_drop", 64'(drop_r15), 64'(1));
    chk("r15_we", 64'(WE3), 64'(0));
    step(1'b1, 1'b0, '0, '0);
    chk("after_r15_a3", 64'(A3), 64'(2));
    idle(2);

    // Six back-to-back requests.
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b1, N'(i + 4), 32'hA000_0000 + 32'(i));
    idle(3);

    // Reset mid-drain: the buffered write must never appear.
    step(1'b1, 1'b1, 4'd9, 32'hBAD0BAD0);
    step(1'b0, 1'b0, '0, '0);
    chk("drain_rst_we", 64'(WE3), 64'(0));
    chk("drain_rst_wd", 64'(WD3), 64'(0));
    if (SWEEP) begin
      // Reset part way through the sweep (while A3=7 is being written).
      idle(8);
      chk("mid_sweep_a3", 64'(A3), 64'(7));
      step(1'b0, 1'b0, '0, '0);
      chk("sweep_rst_a3", 64'(A3), 64'(0));
      idle(15);
    end else begin
      idle(2);
    end

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      logic [N-1:0] ra;
      ra = ($urandom_range(0, 3) == 0) ? N'(PC) : N'($urandom_range(0, PC));
      step(($urandom_range(0, 79) != 0), ($urandom_range(0, 2) != 0), ra, M'($urandom));
    end
    idle(SWEEP ? 20 : 4);

    chk("r15_never_written", 64'(r15_writes), 64'(0));
    chk("final_pending", 64'(pending), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
